// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width and the alu32 control encodings.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1000;
  localparam logic [3:0] ALU_LTU  = 4'b1001;
  localparam logic [3:0] ALU_LT   = 4'b1010;
  localparam logic [3:0] ALU_GEU  = 4'b1011;
  localparam logic [3:0] ALU_GE   = 4'b1100;
  localparam logic [3:0] ALU_JALR = 4'b1101;

  // Codes above this are reported back to the requester as unsupported.
  localparam logic [3:0] ALU_OP_MAX = ALU_JALR;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer names the port that wins the next conflict.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    // After any grant the other port gets priority, even without a conflict.
    ptr_d = ptr_q;
    if (gnt_o != 2'b00) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external alu32 between the execute stage (port 0) and the
// branch/address unit (port 1), with a one-deep registered response per port.
module alu_arbiter #(
  parameter int XLEN   = rv32i_pkg::XLEN,
  parameter int CTRL_W = 4,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*CTRL_W-1:0] req_op,
  input  logic [2*XLEN-1:0]   req_a,
  input  logic [2*XLEN-1:0]   req_b,
  input  logic [2*TAG_W-1:0]  req_tag,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*XLEN-1:0]   rsp_data,
  output logic [2*TAG_W-1:0]  rsp_tag,
  output logic [1:0]          rsp_err,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [XLEN-1:0]     alu_result,
  output logic [CNT_W-1:0]    conflict_cnt
);

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // a response transfers on a cycle where rsp_valid[i] & rsp_ready[i].
  logic [1:0]       rsp_vld;
  logic [1:0]       elig;
  logic [1:0]       arb_req;
  logic [1:0]       grant;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  // A port may issue only if its buffer is empty or draining this cycle.
  assign elig    = req_valid & (~rsp_vld | rsp_ready);
  assign arb_req = rst_n ? elig : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (arb_req),
    .gnt_o (grant)
  );

  assign req_ready = grant;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = CTRL_W'(rv32i_pkg::ALU_ADD);
    for (int p = 0; p < 2; p++) begin
      if (grant[p]) begin
        alu_a    = req_a[p*XLEN +: XLEN];
        alu_b    = req_b[p*XLEN +: XLEN];
        alu_ctrl = req_op[p*CTRL_W +: CTRL_W];
      end
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (elig == 2'b11 && conflict_q != {CNT_W{1'b1}}) conflict_d = conflict_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;

  for (genvar p = 0; p < 2; p++) begin : g_rsp
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    // A grant wins over a drain, so a draining buffer reloads without a bubble.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      tag_d   = tag_q;
      err_d   = err_q;
      if (grant[p]) begin
        valid_d = 1'b1;
        data_d  = alu_result;
        tag_d   = req_tag[p*TAG_W +: TAG_W];
        err_d   = req_op[p*CTRL_W +: CTRL_W] > CTRL_W'(rv32i_pkg::ALU_OP_MAX);
      end else if (rsp_ready[p]) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        tag_q   <= tag_d;
        err_q   <= err_d;
      end
    end

    assign rsp_vld[p]                   = valid_q;
    assign rsp_data[p*XLEN +: XLEN]     = data_q;
    assign rsp_tag[p*TAG_W +: TAG_W]    = tag_q;
    assign rsp_err[p]                   = err_q;
  end

  assign rsp_valid = rsp_vld;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu32 instance between two requesters: port 0 is the execute stage and port 1 is the branch/address unit.
- Round-robin arbitration, a valid/ready request handshake per port, and a registered, buffered response per port.
- Sits between the decode/execute control and the single ALU. The ALU itself stays outside this block and is driven through the alu_* ports.

Parameters:
- XLEN, 32, operand/result width.
- CTRL_W, 4, ALU control width; must match alu32 ALUControl.
- TAG_W, 4, requester tag width, returned unchanged with the result.
- CNT_W, 16, width of the conflict performance counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  2  bit i = port i request valid.
- req_ready  out  2  bit i = port i request accepted this cycle.
- req_op  in  2*CTRL_W  port i ALU control at [i*CTRL_W +: CTRL_W].
- req_a  in  2*XLEN  port i operand a.
- req_b  in  2*XLEN  port i operand b.
- req_tag  in  2*TAG_W  port i tag.
- rsp_valid  out  2  port i response valid.
- rsp_ready  in  2  port i consumer ready.
- rsp_data  out  2*XLEN  port i result.
- rsp_tag  out  2*TAG_W  port i returned tag.
- rsp_err  out  2  port i op was an unsupported code (> 4'b1101).
- alu_a  out  XLEN  to alu32 a.
- alu_b  out  XLEN  to alu32 b.
- alu_ctrl  out  CTRL_W  to alu32 ALUControl.
- alu_result  in  XLEN  from alu32 result (combinational).
- conflict_cnt  out  CNT_W  saturating count of cycles in which both ports were eligible.

Behaviour:
- Eligibility: elig[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]). At most one outstanding result per port; a buffered result may drain and be replaced in the same cycle.
- Grant (combinational):
  - both eligible → port rr_ptr;
  - exactly one eligible → that port;
  - none eligible → no grant.
- req_ready = one-hot grant vector or 0. Never both bits set.
- Requesters hold op/a/b/tag stable while valid and not ready. This block does not check that.
- ALU drive:
  - on a grant, alu_a/alu_b/alu_ctrl = the granted port's fields in the same cycle;
  - with no grant, alu_a = 0, alu_b = 0, alu_ctrl = 4'b0000 (add).
- Capture on the grant edge:
  - rsp_data[g] <= alu_result, rsp_tag[g] <= req_tag[g], rsp_err[g] <= (op > 4'b1101), rsp_valid[g] <= 1;
  - rr_ptr <= ~g.
- Latency: exactly 1 cycle, request handshake to rsp_valid. Throughput: 1 op/cycle total.
- Response: rsp_valid[i] stays high and rsp_data/tag/err stay stable until rsp_valid & rsp_ready. It then clears, unless a new grant to the same port occurs in the same cycle, in which case the new result loads and rsp_valid remains 1.
- The non-granted port's response registers are unchanged.
- rr_ptr moves only on a grant. A single eligible port being granted repeatedly still toggles rr_ptr on every grant.
- conflict_cnt increments in each cycle where elig == 2'b11, and saturates at all-ones.
- Unsupported op: still granted and responded to. rsp_data holds whatever alu_result returns (may be X in simulation) and rsp_err = 1.
- Reset (rst_n low at a rising edge), applied even mid-transaction:
  - rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_err = 0, rr_ptr = 0 (port 0 wins the first conflict), conflict_cnt = 0;
  - while rst_n is low, req_ready = 0 and the alu_* outputs take their idle values;
  - buffered results are discarded.

Decomposition:
- Shared package rv32i_pkg holds:
  - ALU control localparams: ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, AND/OR/XOR, SLL/SRL/SRA, EQ, LTU, LT, GEU, GE, ALU_JALR = 4'b1101;
  - ALU_OP_MAX = 4'b1101;
  - XLEN.
- One sub-module is natural: rr_arb2, a 2-way round-robin grant with a pointer register and an enable-on-grant update. The response buffer is a generate loop over the ports inside alu_arbiter.

Test Plan:
- Single request: port 0 sends op = ADD, a = 5, b = 7, tag = 3 → req_ready = 01 in the same cycle, alu_ctrl = 0000, next cycle rsp_valid = 01, rsp_data0 = 12, rsp_tag0 = 3, rsp_err0 = 0.
- Conflict rotation: both ports valid every cycle, rsp_ready = 11; port 0 op = SUB 10,3 and port 1 op = LT 0xFFFFFFFF,1 → grants alternate 01, 10, 01, ...; data0 = 7 and data1 = 1; conflict_cnt increments by 1 per cycle.
- Backpressure: rsp_ready0 = 0 with a second port-0 request pending → req_ready0 = 0 and rsp_data0 is held. Raising rsp_ready0 → port 0 is granted in the same cycle, and the next cycle shows new data with rsp_valid0 still 1.
- Illegal op: port 1 op = 4'b1110 → granted, and after 1 cycle rsp_valid1 = 1 and rsp_err1 = 1.
- Reset mid-operation: rst_n low for 1 cycle while rsp_valid = 11 and both ports are requesting → next cycle rsp_valid = 00, conflict_cnt = 0, and the first conflict afterwards grants port 0.
- Saturation: with CNT_W = 4, hold both ports eligible for 20 cycles → conflict_cnt stops at 15.
